// File: rtl/d_cache_if.sv
// rtl/d_cache_if.sv - CPU request/response and data_ram bus bundle for d_cache
interface d_cache_if;
   logic        addr_valid;
   logic        addr_ready;
   logic [31:0] addr;
   logic        we;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        data_valid;
   logic        data_ready;
   logic [15:0] mem_addr;
   logic        mem_we;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   // master: the CPU plus data_ram environment; slave: the cache itself
   modport master (
      output addr_valid, addr, we, wdata, data_ready, mem_rdata,
      input  addr_ready, rdata, data_valid, mem_addr, mem_we, mem_wdata
   );
   modport slave (
      input  addr_valid, addr, we, wdata, data_ready, mem_rdata,
      output addr_ready, rdata, data_valid, mem_addr, mem_we, mem_wdata
   );
endinterface

// File: rtl/d_cache.sv
// rtl/d_cache.sv - direct-mapped write-through no-write-allocate data cache
// Optional hit/miss counters enabled by macro DCACHE_STATS_EN.
module d_cache #(
   parameter int INDEX_WIDTH  = 4,
   parameter int OFFSET_WIDTH = 2
) (
   input  logic        clk,
   input  logic        resetn,
   d_cache_if.slave    bus
`ifdef DCACHE_STATS_EN
   ,
   output logic [31:0] hit_cnt,
   output logic [31:0] miss_cnt
`endif
);
   localparam int LINES = 1 << INDEX_WIDTH;
   localparam int WORDS = 1 << OFFSET_WIDTH;
   localparam int TAG_W = 16 - INDEX_WIDTH - OFFSET_WIDTH;

   typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_REFILL, S_WRITE, S_RESP} state_t;

   state_t                  r_state, w_next;
   logic [15:0]             r_waddr;
   logic                    r_we;
   logic [31:0]             r_wdata;
   logic [31:0]             r_rdata;
   logic [OFFSET_WIDTH-1:0] r_cnt;
   logic [LINES-1:0]        r_valid;
   logic [TAG_W-1:0]        r_tag  [LINES];
   logic [31:0]             r_line [LINES][WORDS];

   logic [OFFSET_WIDTH-1:0] w_off;
   logic [INDEX_WIDTH-1:0]  w_idx;
   logic [TAG_W-1:0]        w_tag;
   logic                    w_hit;
   logic                    w_last;
   logic                    w_unused_addr;

   assign w_off  = r_waddr[OFFSET_WIDTH-1:0];
   assign w_idx  = r_waddr[OFFSET_WIDTH+INDEX_WIDTH-1:OFFSET_WIDTH];
   assign w_tag  = r_waddr[15:OFFSET_WIDTH+INDEX_WIDTH];
   assign w_hit  = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
   assign w_last = (r_cnt == OFFSET_WIDTH'(WORDS - 1));
   assign w_unused_addr = &{1'b0, bus.addr[31:18], bus.addr[1:0]};

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next         = r_state;
      bus.addr_ready = 1'b0;
      bus.data_valid = 1'b0;
      bus.rdata      = r_rdata;
      bus.mem_we     = 1'b0;
      bus.mem_addr   = '0;
      bus.mem_wdata  = '0;
      case (r_state)
         S_IDLE: begin
            bus.addr_ready = 1'b1;
            if (bus.addr_valid) w_next = S_LOOKUP;
         end
         S_LOOKUP: begin
            if (r_we)       w_next = S_WRITE;
            else if (w_hit) w_next = S_RESP;
            else            w_next = S_REFILL;
         end
         S_REFILL: begin
            bus.mem_addr = {w_tag, w_idx, r_cnt};
            if (w_last) w_next = S_RESP;
         end
         S_WRITE: begin
            bus.mem_we    = 1'b1;
            bus.mem_addr  = r_waddr;
            bus.mem_wdata = r_wdata;
            w_next        = S_RESP;
         end
         S_RESP: begin
            bus.data_valid = 1'b1;
            if (bus.data_ready) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_waddr <= '0;
         r_we    <= 1'b0;
         r_wdata <= '0;
         r_rdata <= '0;
         r_cnt   <= '0;
         r_valid <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.addr_valid) begin
                  r_waddr <= bus.addr[17:2];
                  r_we    <= bus.we;
                  r_wdata <= bus.wdata;
               end
            end
            S_LOOKUP: begin
               if (!r_we) begin
                  if (w_hit) begin
                     r_rdata <= r_line[w_idx][w_off];
                  end else begin
                     // the line is being overwritten, so it stays invalid until fully refilled
                     r_cnt          <= '0;
                     r_valid[w_idx] <= 1'b0;
                  end
               end
            end
            S_REFILL: begin
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == w_off) r_rdata <= bus.mem_rdata;
               if (w_last) r_valid[w_idx] <= 1'b1;
            end
            S_WRITE: r_rdata <= '0;
            default: ;
         endcase
      end
   end

   // line storage carries no reset; validity alone decides whether it is usable
   always_ff @(posedge clk) begin
      if (r_state == S_REFILL) begin
         r_line[w_idx][r_cnt] <= bus.mem_rdata;
         if (w_last) r_tag[w_idx] <= w_tag;
      end
      if (r_state == S_WRITE && w_hit) begin
         r_line[w_idx][w_off] <= r_wdata;
      end
   end

`ifdef DCACHE_STATS_EN
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         hit_cnt  <= '0;
         miss_cnt <= '0;
      end else if (r_state == S_LOOKUP) begin
         if (w_hit) hit_cnt  <= hit_cnt + 32'd1;
         else       miss_cnt <= miss_cnt + 32'd1;
      end
   end
`endif
endmodule

// File: tb/tb_d_cache.sv
// tb/tb_d_cache.sv - scoreboard bench for d_cache against a line-level reference model
module tb_d_cache;
   localparam int IW    = 4;
   localparam int OW    = 2;
   localparam int LINES = 1 << IW;
   localparam int WORDS = 1 << OW;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   always #5 clk = ~clk;

   d_cache_if bus();
`ifdef DCACHE_STATS_EN
   logic [31:0] hit_cnt, miss_cnt;
`endif

   d_cache #(.INDEX_WIDTH(IW), .OFFSET_WIDTH(OW)) dut (
      .clk      (clk),
      .resetn   (resetn),
      .bus      (bus)
`ifdef DCACHE_STATS_EN
      ,
      .hit_cnt  (hit_cnt),
      .miss_cnt (miss_cnt)
`endif
   );

   typedef struct {logic [31:0] rd; int lat; int acc;} exp_t;
   typedef struct {logic [15:0] a; logic [31:0] d;} wr_t;

   logic [31:0] ram     [65536];
   logic [31:0] ref_mem [65536];
   bit          mvalid  [LINES];
   int          mtag    [LINES];
   int          mhits, mmiss;
   exp_t        expq[$];
   wr_t         wrq[$];
   int          checks, failures, cyc;
   int          hold_tokens, hold_used, hold_left;
   bit          in_resp;
   logic [31:0] cur_rd;

   assign bus.mem_rdata = ram[bus.mem_addr];

   always @(posedge clk) begin
      cyc++;
      if (bus.mem_we) ram[bus.mem_addr] = bus.mem_wdata;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Reference: memory is always current, so a load returns memory contents;
   // only the per-line valid/tag bookkeeping decides the latency.
   task automatic model(input bit we, input logic [15:0] w, input logic [31:0] wd,
                        output logic [31:0] rd, output int lat);
      int idx, tg;
      bit hit;
      idx = (int'(w) / WORDS) % LINES;
      tg  = int'(w) / (WORDS * LINES);
      hit = mvalid[idx] && (mtag[idx] == tg);
      if (hit) mhits++; else mmiss++;
      if (we) begin
         ref_mem[w] = wd;
         wrq.push_back('{w, wd});
         rd  = 32'd0;
         lat = 3;
      end else begin
         rd  = ref_mem[w];
         lat = hit ? 2 : 2 + WORDS;
         if (!hit) begin
            mvalid[idx] = 1'b1;
            mtag[idx]   = tg;
         end
      end
   endtask

   task automatic issue(input bit we, input logic [31:0] a, input logic [31:0] wd);
      int n;
      exp_t e;
      logic [15:0] w;
      n = 0;
      @(negedge clk);
      while (!bus.addr_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!bus.addr_ready) begin
         checks++;
         failures++;
         $display("FAIL issue_timeout: addr_ready=%b required 1", bus.addr_ready);
         return;
      end
      w = a[17:2];
      model(we, w, wd, e.rd, e.lat);
      e.acc = cyc + 1;
      expq.push_back(e);
      bus.addr_valid = 1'b1;
      bus.we         = we;
      bus.addr       = a;
      bus.wdata      = wd;
      @(posedge clk);
      #1;
      bus.addr_valid = 1'b0;
      bus.addr       = $urandom;
      bus.we         = 1'($urandom);
      bus.wdata      = $urandom;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((expq.size() != 0 || in_resp) && n < 500) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (expq.size() != 0 || in_resp) begin
         failures++;
         $display("FAIL drain_timeout: pending=%0d required 0", expq.size());
      end
   endtask

   // Monitor: pops the scoreboard on each new response, checks stability under backpressure
   always @(negedge clk) begin
      exp_t e;
      wr_t  wr;
      if (!resetn) begin
         in_resp   = 1'b0;
         hold_left = 0;
         bus.data_ready = 1'b0;
      end else begin
         if (in_resp && bus.data_ready) in_resp = 1'b0;
         if (bus.data_valid) begin
            chk("addr_ready_in_resp", {31'd0, bus.addr_ready}, 32'd0);
            if (!in_resp) begin
               if (expq.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected_resp: rdata=%h required no response", bus.rdata);
               end else begin
                  e = expq.pop_front();
                  chk("rdata", bus.rdata, e.rd);
                  chk("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
                  cur_rd = e.rd;
               end
               in_resp = 1'b1;
               if (hold_tokens > hold_used) begin
                  hold_used++;
                  hold_left = 5;
               end
            end else begin
               chk("rdata_stable", bus.rdata, cur_rd);
            end
         end
         if (bus.data_valid && hold_left > 0) begin
            bus.data_ready = 1'b0;
            hold_left--;
         end else begin
            bus.data_ready = ($urandom_range(0, 3) != 0);
         end
         if (bus.mem_we) begin
            if (wrq.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_write: addr=%h required no write", bus.mem_addr);
            end else begin
               wr = wrq.pop_front();
               chk("write_addr", {16'd0, bus.mem_addr}, {16'd0, wr.a});
               chk("write_data", bus.mem_wdata, wr.d);
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time exceeded");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      int mism;
      logic [31:0] a, w;
      bus.addr_valid = 1'b0;
      bus.addr       = '0;
      bus.we         = 1'b0;
      bus.wdata      = '0;
      for (int i = 0; i < 65536; i++) begin
         ram[i]     = $urandom;
         ref_mem[i] = ram[i];
      end
      for (int k = 0; k < 4; k++) begin
         ram[16 + k]     = 32'hA0 + k;
         ref_mem[16 + k] = 32'hA0 + k;
      end
      repeat (3) @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      chk("rst_addr_ready", {31'd0, bus.addr_ready}, 32'd1);
      chk("rst_data_valid", {31'd0, bus.data_valid}, 32'd0);
      chk("rst_rdata", bus.rdata, 32'd0);
      chk("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
      chk("rst_mem_addr", {16'd0, bus.mem_addr}, 32'd0);
      chk("rst_mem_wdata", bus.mem_wdata, 32'd0);

      // cold load with refill address sequence
      issue(1'b0, 32'h48, 32'd0);
      @(negedge clk);
      chk("lookup_mem_addr", {16'd0, bus.mem_addr}, 32'd0);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("refill_addr", {16'd0, bus.mem_addr}, 32'h10 + k);
      end
      drain();
      issue(1'b0, 32'h44, 32'd0);
      @(negedge clk);
      chk("hit_no_traffic", {16'd0, bus.mem_addr}, 32'd0);
      @(negedge clk);
      chk("hit_no_traffic", {16'd0, bus.mem_addr}, 32'd0);
      drain();
      issue(1'b1, 32'h40, 32'h12345678);
      issue(1'b0, 32'h40, 32'd0);
      issue(1'b1, 32'h4040, 32'hCAFEF00D);
      issue(1'b0, 32'h4040, 32'd0);
      issue(1'b0, 32'h40, 32'd0);
      drain();
      hold_tokens++;
      issue(1'b0, 32'h40, 32'd0);
      drain();

      for (int t = 0; t < 300; t++) begin
         w = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
         a = ($urandom & 32'hFFFC_0003) | (w << 2);
         issue($urandom_range(0, 9) < 4, a, $urandom);
      end
      drain();
`ifdef DCACHE_STATS_EN
      chk("hit_cnt", hit_cnt, 32'(mhits));
      chk("miss_cnt", miss_cnt, 32'(mmiss));
`endif

      // reset during the second refill cycle
      @(negedge clk);
      bus.addr_valid = 1'b1;
      bus.we         = 1'b0;
      bus.addr       = 32'h8048;
      @(posedge clk);
      #1 bus.addr_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2 resetn = 1'b0;
      #1;
      chk("mid_rst_addr_ready", {31'd0, bus.addr_ready}, 32'd1);
      chk("mid_rst_data_valid", {31'd0, bus.data_valid}, 32'd0);
      chk("mid_rst_rdata", bus.rdata, 32'd0);
      chk("mid_rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
      chk("mid_rst_mem_addr", {16'd0, bus.mem_addr}, 32'd0);
      chk("mid_rst_mem_wdata", bus.mem_wdata, 32'd0);
      for (int i = 0; i < LINES; i++) mvalid[i] = 1'b0;
      mhits = 0;
      mmiss = 0;
`ifdef DCACHE_STATS_EN
      chk("rst_hit_cnt", hit_cnt, 32'd0);
      chk("rst_miss_cnt", miss_cnt, 32'd0);
`endif
      @(negedge clk);
      resetn = 1'b1;
      issue(1'b0, 32'h8048, 32'd0);
      issue(1'b0, 32'h8048, 32'd0);
      drain();

      mism = 0;
      for (int i = 0; i < 16'h2100; i++) if (ram[i] !== ref_mem[i]) mism++;
      chk("ram_image", 32'(mism), 32'd0);
      chk("writes_pending", 32'(wrq.size()), 32'd0);
`ifdef DCACHE_STATS_EN
      chk("final_hit_cnt", hit_cnt, 32'(mhits));
      chk("final_miss_cnt", miss_cnt, 32'(mmiss));
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
